// File: rtl/uart_tx_ctrl_if.sv
// UART TX FIFO read port: show-ahead head word plus a one-clk pop strobe.
// The frame sequencer is the master (it decides when to pop).
interface uart_tx_ctrl_if;
    logic       tfifo_empty;
    logic [8:0] tfifo_rdata;
    logic       tfifo_rd_en;

    modport master (
        input  tfifo_empty,
        input  tfifo_rdata,
        output tfifo_rd_en
    );

    modport slave (
        output tfifo_empty,
        output tfifo_rdata,
        input  tfifo_rd_en
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: start, 8/9 data bits LSB-first, optional parity,
// stop period; paced by the oversample tick, format snapshotted per frame.
module uart_tx_ctrl #(
    parameter int OVS_LOG2 = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           baud_tick,
    input  logic           cr0_te,
    input  logic           cr0_wdlen,
    input  logic           cr0_pce,
    input  logic           cr0_ps,
    input  logic [1:0]     cr0_stoplen,
    uart_tx_ctrl_if.master fifo,
    input  logic           tc_clr,
    output logic           txd,
    output logic           tx_busy,
    output logic           sr_tc
);
    localparam int TW  = OVS_LOG2 + 1;
    localparam int OVS = 1 << OVS_LOG2;
    localparam logic [TW-1:0] BIT_LAST = TW'(OVS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state;
    logic [8:0]    shift;
    logic [TW-1:0] tick_cnt;
    logic [3:0]    bit_cnt;
    logic          acc;
    logic          wdlen_q;
    logic          pce_q;
    logic          ps_q;
    logic [1:0]    stoplen_q;

    logic [TW-1:0] stop_last;
    logic [TW-1:0] cur_last;
    logic [3:0]    bit_last;
    logic          tick_end;
    logic          acc_nxt;
    logic          pop;

    // last tick index of the stop period for the latched stop length
    always_comb begin
        case (stoplen_q)
            2'b00:   stop_last = TW'(OVS - 1);
            2'b01:   stop_last = TW'(OVS / 2 - 1);
            2'b10:   stop_last = TW'(2 * OVS - 1);
            default: stop_last = TW'(OVS + OVS / 2 - 1);
        endcase
    end

    // comparing against last-index keeps the 2-bit stop inside TW bits
    assign cur_last = (state == STOP) ? stop_last : BIT_LAST;
    assign tick_end = baud_tick && (tick_cnt == cur_last);
    assign bit_last = wdlen_q ? 4'd8 : 4'd7;
    assign acc_nxt  = acc ^ shift[0];

    // pop is combinational so the head word is latched on the same edge;
    // gated by rst_n so nothing is consumed while held in reset
    assign pop = rst_n && (state == IDLE) && cr0_te && !fifo.tfifo_empty;
    assign fifo.tfifo_rd_en = pop;

    // frame FSM with bit timing, shifter, parity and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift     <= '0;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            acc       <= 1'b0;
            wdlen_q   <= 1'b0;
            pce_q     <= 1'b0;
            ps_q      <= 1'b0;
            stoplen_q <= 2'b00;
            txd       <= 1'b1;
            tx_busy   <= 1'b0;
            sr_tc     <= 1'b1;
        end else begin
            if (tc_clr) begin
                sr_tc <= 1'b0;
            end
            if (state != IDLE && baud_tick) begin
                tick_cnt <= tick_end ? '0 : tick_cnt + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    txd     <= 1'b1;
                    tx_busy <= 1'b0;
                    if (pop) begin
                        shift     <= fifo.tfifo_rdata;
                        wdlen_q   <= cr0_wdlen;
                        pce_q     <= cr0_pce;
                        ps_q      <= cr0_ps;
                        stoplen_q <= cr0_stoplen;
                        tick_cnt  <= '0;
                        acc       <= 1'b0;
                        sr_tc     <= 1'b0;
                        txd       <= 1'b0;
                        tx_busy   <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (tick_end) begin
                        bit_cnt <= '0;
                        txd     <= shift[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (tick_end) begin
                        shift   <= shift >> 1;
                        acc     <= acc_nxt;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == bit_last) begin
                            if (pce_q) begin
                                txd   <= acc_nxt ^ ps_q;
                                state <= PARITY;
                            end else begin
                                txd   <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            txd <= shift[1];
                        end
                    end
                end
                PARITY: begin
                    if (tick_end) begin
                        txd   <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (tick_end) begin
                        tx_busy <= 1'b0;
                        state   <= IDLE;
                        if (fifo.tfifo_empty) begin
                            sr_tc <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: frame-as-segment-list model plus FIFO queue,
// compared every clk; directed frames pin the model with literal values.
module tb_uart_tx_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       baud_tick;
    logic       cr0_te;
    logic       cr0_wdlen;
    logic       cr0_pce;
    logic       cr0_ps;
    logic [1:0] cr0_stoplen;
    logic       tc_clr;
    logic       txd;
    logic       tx_busy;
    logic       sr_tc;

    uart_tx_ctrl_if f();

    uart_tx_ctrl #(.OVS_LOG2(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .baud_tick   (baud_tick),
        .cr0_te      (cr0_te),
        .cr0_wdlen   (cr0_wdlen),
        .cr0_pce     (cr0_pce),
        .cr0_ps      (cr0_ps),
        .cr0_stoplen (cr0_stoplen),
        .fifo        (f),
        .tc_clr      (tc_clr),
        .txd         (txd),
        .tx_busy     (tx_busy),
        .sr_tc       (sr_tc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] q[$];
    bit         seg_lvl[$];
    int         seg_len[$];
    int         cnt;
    bit         m_busy;
    bit         m_txd;
    bit         m_tc;

    bit          rand_mode;
    int          busy_cyc;
    int          pops;
    int          gaps;
    logic [15:0] samp;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic int stop_ticks(logic [1:0] sl);
        case (sl)
            2'b00:   return 16;
            2'b01:   return 8;
            2'b10:   return 32;
            default: return 24;
        endcase
    endfunction

    task automatic model_adv(input bit pop);
        logic [8:0] w;
        int         nb;
        bit         par;
        bit         fin;
        if (!m_busy) begin
            if (pop) begin
                w   = q.pop_front();
                nb  = cr0_wdlen ? 9 : 8;
                par = cr0_ps;
                seg_lvl.push_back(1'b0);
                seg_len.push_back(16);
                for (int i = 0; i < nb; i++) begin
                    seg_lvl.push_back(w[i]);
                    seg_len.push_back(16);
                    par ^= w[i];
                end
                if (cr0_pce) begin
                    seg_lvl.push_back(par);
                    seg_len.push_back(16);
                end
                seg_lvl.push_back(1'b1);
                seg_len.push_back(stop_ticks(cr0_stoplen));
                cnt    = 0;
                m_busy = 1'b1;
                m_tc   = 1'b0;
                m_txd  = seg_lvl[0];
            end else begin
                m_txd = 1'b1;
                if (tc_clr) m_tc = 1'b0;
            end
        end else begin
            fin = 1'b0;
            if (baud_tick) begin
                cnt++;
                if (cnt == seg_len[0]) begin
                    void'(seg_lvl.pop_front());
                    void'(seg_len.pop_front());
                    cnt = 0;
                    if (seg_lvl.size() == 0) fin = 1'b1;
                    else m_txd = seg_lvl[0];
                end
            end
            if (fin) begin
                m_busy = 1'b0;
                m_txd  = 1'b1;
                if (q.size() == 0) m_tc = 1'b1;
                else if (tc_clr) m_tc = 1'b0;
            end else if (tc_clr) begin
                m_tc = 1'b0;
            end
        end
    endtask

    // one clk: compare registered outputs, drive inputs, check pop, advance
    task automatic step();
        bit pop;
        check("txd", txd, m_txd);
        check("tx_busy", tx_busy, m_busy);
        check("sr_tc", sr_tc, m_tc);
        if (tx_busy) begin
            if (busy_cyc % 16 == 8) samp = {samp[14:0], txd};
            busy_cyc++;
        end else if (q.size() != 0) begin
            gaps++;
        end
        if (rand_mode) begin
            baud_tick   = ($urandom_range(0, 1) == 1);
            tc_clr      = ($urandom_range(0, 15) == 0);
            cr0_te      = ($urandom_range(0, 9) != 0);
            cr0_wdlen   = 1'($urandom);
            cr0_pce     = 1'($urandom);
            cr0_ps      = 1'($urandom);
            cr0_stoplen = 2'($urandom);
            if (q.size() < 4 && $urandom_range(0, 99) < 3) q.push_back(9'($urandom));
        end
        f.tfifo_empty = (q.size() == 0);
        f.tfifo_rdata = (q.size() != 0) ? q[0] : 9'h1FF;
        #1;
        pop = !m_busy && cr0_te && (q.size() != 0);
        check("tfifo_rd_en", f.tfifo_rd_en, pop);
        if (f.tfifo_rd_en) pops++;
        model_adv(pop);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_cfg(input bit wl, input bit pe, input bit ps, input logic [1:0] sl);
        cr0_wdlen   = wl;
        cr0_pce     = pe;
        cr0_ps      = ps;
        cr0_stoplen = sl;
    endtask

    task automatic clr_stats();
        busy_cyc = 0;
        pops     = 0;
        gaps     = 0;
        samp     = '0;
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        check("ar_txd", txd, 1);
        check("ar_busy", tx_busy, 0);
        check("ar_tc", sr_tc, 1);
        check("ar_rd_en", f.tfifo_rd_en, 0);
        m_busy = 1'b0;
        m_txd  = 1'b1;
        m_tc   = 1'b1;
        cnt    = 0;
        seg_lvl.delete();
        seg_len.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        baud_tick     = 1'b1;
        cr0_te        = 1'b0;
        tc_clr        = 1'b0;
        rand_mode     = 1'b0;
        f.tfifo_empty = 1'b1;
        f.tfifo_rdata = '0;
        set_cfg(0, 0, 0, 2'b00);
        m_busy = 1'b0;
        m_txd  = 1'b1;
        m_tc   = 1'b1;
        cnt    = 0;
        clr_stats();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_txd", txd, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_tc", sr_tc, 1);
        repeat (3) step();

        // 8N1 0x55, tick every clk
        cr0_te = 1'b1;
        clr_stats();
        q.push_back(9'h055);
        repeat (200) step();
        check("t1_busy_clks", busy_cyc, 160);
        check("t1_bits", samp[9:0], 10'h155);
        check("t1_pops", pops, 1);
        check("t1_tc", sr_tc, 1);

        // 9 data bits, even parity, 0x1A5
        set_cfg(1, 1, 0, 2'b00);
        clr_stats();
        q.push_back(9'h1A5);
        repeat (230) step();
        check("t2_busy_clks", busy_cyc, 192);
        check("t2_bits", samp[11:0], 12'h52F);

        // odd parity of 0x00, 2 stop bits
        set_cfg(0, 1, 1, 2'b10);
        clr_stats();
        q.push_back(9'h000);
        repeat (230) step();
        check("t3_busy_clks", busy_cyc, 192);
        check("t3_bits", samp[11:0], 12'h007);

        // half stop bit
        set_cfg(0, 1, 1, 2'b01);
        clr_stats();
        q.push_back(9'h000);
        repeat (200) step();
        check("t4_busy_clks", busy_cyc, 168);
        check("t4_bits", samp[9:0], 10'h001);

        // three frames back-to-back, tc_clr during frame 2
        set_cfg(0, 0, 0, 2'b00);
        clr_stats();
        q.push_back(9'h0F0);
        q.push_back(9'h033);
        q.push_back(9'h1C3);
        repeat (200) step();
        tc_clr = 1'b1;
        step();
        tc_clr = 1'b0;
        repeat (320) step();
        check("b2b_pops", pops, 3);
        check("b2b_busy_clks", busy_cyc, 480);
        check("b2b_idle_clks", gaps, 3);
        check("b2b_tc", sr_tc, 1);

        // te dropped in DATA with a word still queued
        clr_stats();
        q.push_back(9'h0A6);
        q.push_back(9'h011);
        repeat (72) step();
        cr0_te = 1'b0;
        repeat (200) step();
        check("te_pops", pops, 1);
        check("te_busy", tx_busy, 0);
        check("te_tc", sr_tc, 0);
        cr0_te = 1'b1;
        repeat (200) step();
        check("te_drain_pops", pops, 2);

        // async reset mid-DATA, then a clean frame
        clr_stats();
        q.push_back(9'h000);
        q.push_back(9'h0C5);
        repeat (40) step();
        async_reset();
        clr_stats();
        repeat (200) step();
        check("rst_next_busy_clks", busy_cyc, 160);
        check("rst_next_pops", pops, 1);

        // randomized traffic, ticks and config
        rand_mode = 1'b1;
        repeat (6000) step();
        rand_mode = 1'b0;
        tc_clr    = 1'b0;
        cr0_te    = 1'b1;
        baud_tick = 1'b1;
        repeat (1200) step();
        check("drain_busy", tx_busy, 0);
        check("drain_tc", sr_tc, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- TX frame sequencer for the UART. Pops words from the show-ahead TX FIFO and serialises them onto the txd line: start bit, 8 or 9 data bits LSB-first, optional parity bit, then the stop period.
- Timed by the 16x oversample tick from the baud generator. Frame format comes from the CR0 fields. Drives the SR TC flag and a busy indication.

Parameters:
- OVS_LOG2, 4, log2 of oversample ticks per bit (16 ticks/bit).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- baud_tick  in  1  one-clk pulse, OVS ticks per bit period
- cr0_te  in  1  TX enable
- cr0_wdlen  in  1  0: 8 data bits, 1: 9 data bits
- cr0_pce  in  1  parity enable
- cr0_ps  in  1  0: even, 1: odd
- cr0_stoplen  in  2  00: 1 bit, 01: 0.5 bit, 10: 2 bits, 11: 1.5 bits
- tfifo_empty  in  1  TX FIFO empty
- tfifo_rdata  in  9  FIFO head word, valid whenever !tfifo_empty
- tfifo_rd_en  out  1  pop strobe, one clk
- tc_clr  in  1  clear TC (SR write-0 path)
- txd  out  1  serial output, idle high
- tx_busy  out  1  frame in progress
- sr_tc  out  1  transmission complete

Behaviour:
- Reset (async, rst_n=0): txd=1, tfifo_rd_en=0, tx_busy=0, sr_tc=1, FSM=IDLE, counters=0. Reset mid-frame aborts the frame; txd returns high immediately.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If cr0_te && !tfifo_empty: pulse tfifo_rd_en for exactly that clk.
  - In the same clk, latch tfifo_rdata into the shift register, snapshot wdlen/pce/ps/stoplen, clear tick_cnt and the parity accumulator, clear sr_tc, and go to START.
  - Otherwise remain in IDLE with txd=1.
- Bit timing: tick_cnt (OVS_LOG2+1 bits) advances only on baud_tick. A bit ends on the baud_tick that brings tick_cnt to 16. At that point tick_cnt is cleared.
- START: txd=0 for 16 ticks, then go to DATA with bit_cnt=0.
- DATA:
  - txd = shift[0] for the bit. At bit end, shift right, XOR the bit into the parity accumulator, and increment bit_cnt.
  - Leave after bit 8 (wdlen=0) or bit 9 (wdlen=1). Go to PARITY if pce, else STOP.
  - In 8-bit mode, bit 8 of the latched word is ignored.
- PARITY:
  - Parity is an extra appended bit; it does not replace the data MSB.
  - txd = acc XOR ps for 16 ticks, then go to STOP. Even parity gives an even total count of ones over data+parity.
- STOP:
  - txd=1 for 16/8/32/24 ticks (stoplen 00/01/10/11).
  - At the end, go to IDLE. If the FIFO is empty at that clk, set sr_tc=1.
- Back-to-back: a non-empty FIFO is popped in the clk after STOP ends. The inter-frame gap is 1 clk, not bit-aligned, and sr_tc stays 0.
- tx_busy=1 in every state except IDLE.
- cr0_te deasserted mid-frame: the current frame completes, including stop bits. No further pop occurs while te=0.
- Config changes mid-frame are ignored; the snapshot is used until IDLE.
- tc_clr clears sr_tc in the next clk. If it coincides with the STOP-end set event, the set wins.
- baud_tick outside a frame has no effect.
- Pop/empty rule: tfifo_rd_en is never asserted when tfifo_empty=1.

Test Plan:
- Reset, te=1, push 0x55, 8N1, baud_tick every clk -> one tfifo_rd_en pulse; txd = 0, then 1,0,1,0,1,0,1,0, then 1, each bit 16 clks; sr_tc=1 at end; total 160 clks busy.
- wdlen=1, pce=1, ps=0, push 0x1A5 (five ones) -> 9 data bits 1,0,1,0,0,1,0,1,1, then parity=1, then stop; frame 12 bits = 192 ticks.
- ps=1, pce=1, 8-bit 0x00 -> parity bit 1; stoplen=10 -> stop high for 32 ticks; stoplen=01 -> 8 ticks.
- Push 3 words back-to-back -> 3 pops; 1-clk high gap between frames; sr_tc stays 0 until the 3rd STOP ends; tc_clr during frame 2 holds tc=0.
- Drop te at bit 3 of a frame with 2 words queued -> frame finishes; no second pop; tx_busy=0; sr_tc=0 (FIFO non-empty).
- Assert rst_n=0 mid-DATA -> txd=1 and tx_busy=0 asynchronously; after release with the FIFO non-empty and te=1, the next frame starts cleanly with START.
